// File: rtl/pipe_ctrl.sv
// Central sequencing controller for the 5-stage pipeline: stage enables, flushes,
// PC control, data-request gating, halt and wrapping performance counters.
module pipe_ctrl #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_req,
   input  logic             mem_halt,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_branch_taken,
   input  logic             id_jump,
   output logic             pc_en,
   output logic [1:0]       pc_sel,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             dmem_gate,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, DDONE, HALT} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             w_adv;
   logic             w_lu;

   always_comb begin
      w_adv = 1'b0;
      case (r_state)
         RUN:     w_adv = ihit & (~mem_req | dhit);
         DDONE:   w_adv = ihit;
         default: w_adv = 1'b0;
      endcase
   end

   assign w_lu = ex_memread & (ex_rd != '0) &
                 ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

   // Hazard resolution only matters on advancing cycles; frozen stages keep their inputs stable.
   always_comb begin
      pc_en      = 1'b0;
      pc_sel     = 2'b00;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      if (w_adv) begin
         pc_en    = 1'b1;
         ifid_en  = 1'b1;
         idex_en  = 1'b1;
         exmem_en = 1'b1;
         memwb_en = 1'b1;
         if (ex_branch_taken) begin
            pc_sel     = 2'b01;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (w_lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end else if (id_jump) begin
            pc_sel     = 2'b10;
            ifid_flush = 1'b1;
         end
      end
   end

   assign dmem_gate = (r_state == RUN);
   assign halted    = (r_state == HALT);
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;

   // DDONE remembers a finished data access so the request is masked until fetch catches up.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state     <= RUN;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         case (r_state)
            RUN: begin
               if (mem_req & dhit & ~ihit)
                  r_state <= DDONE;
               else if (w_adv & mem_halt)
                  r_state <= HALT;
            end
            DDONE: begin
               if (ihit)
                  r_state <= RUN;
            end
            default: r_state <= HALT;
         endcase
         if (!w_adv && r_state != HALT)
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_adv && (ifid_flush || idex_flush))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; a second narrow-counter instance shares the inputs
// so counter wrap can be observed within a few cycles.
module tb_pipe_ctrl;

   logic       CLK;
   logic       nRST;
   logic       ihit, dhit, mem_req, mem_halt, ex_memread;
   logic [4:0] ex_rd, id_rs, id_rt;
   logic       id_uses_rt, ex_branch_taken, id_jump;

   logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic [1:0]  pc_sel;
   logic        ifid_flush, idex_flush, dmem_gate, halted;
   logic [31:0] stall_cnt, flush_cnt;

   logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
   logic [1:0]  s_pc_sel;
   logic        s_ifid_flush, s_idex_flush, s_dmem_gate, s_halted;
   logic [1:0]  s_stall_cnt, s_flush_cnt;

   int checks = 0;
   int errors = 0;

   pipe_ctrl #(.REG_W(5), .CNT_W(32)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
      .mem_halt(mem_halt), .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs),
      .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_branch_taken(ex_branch_taken),
      .id_jump(id_jump), .pc_en(pc_en), .pc_sel(pc_sel), .ifid_en(ifid_en),
      .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .dmem_gate(dmem_gate),
      .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipe_ctrl #(.REG_W(5), .CNT_W(2)) dut_small (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
      .mem_halt(mem_halt), .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs),
      .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_branch_taken(ex_branch_taken),
      .id_jump(id_jump), .pc_en(s_pc_en), .pc_sel(s_pc_sel), .ifid_en(s_ifid_en),
      .idex_en(s_idex_en), .exmem_en(s_exmem_en), .memwb_en(s_memwb_en),
      .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .dmem_gate(s_dmem_gate),
      .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic clear_inputs();
      ihit = 0; dhit = 0; mem_req = 0; mem_halt = 0; ex_memread = 0;
      ex_rd = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
      ex_branch_taken = 0; id_jump = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      nRST = 1'b1;
      #1 nRST = 1'b0;
      #2;
      checks++;
      if ({stall_cnt, flush_cnt, halted, dmem_gate} !== {32'd0, 32'd0, 1'b0, 1'b1}) begin
         $display("FAIL reset_init got stall=%0d flush=%0d halted=%b gate=%b exp 0 0 0 1",
                  stall_cnt, flush_cnt, halted, dmem_gate);
         errors++;
      end
      @(negedge CLK) nRST = 1'b1;
      // six plain stalls, then a data hit with fetch pending -> DDONE, stall_cnt=7
      repeat (6) tick();
      mem_req = 1; dhit = 1;
      tick();
      mem_req = 1; dhit = 0;
      #1;
      checks++;
      if ({dmem_gate, stall_cnt} !== {1'b0, 32'd7}) begin
         $display("FAIL reset_pre_ddone got gate=%b stall=%0d exp 0 7", dmem_gate, stall_cnt);
         errors++;
      end
      #1 nRST = 1'b0;
      #1;
      checks++;
      if ({stall_cnt, flush_cnt, halted, dmem_gate} !== {32'd0, 32'd0, 1'b0, 1'b1}) begin
         $display("FAIL reset_async got stall=%0d flush=%0d halted=%b gate=%b exp 0 0 0 1",
                  stall_cnt, flush_cnt, halted, dmem_gate);
         errors++;
      end
      clear_inputs();
      @(negedge CLK) nRST = 1'b1;
   endtask

   task automatic test_load_use();
      ihit = 1; ex_memread = 1; ex_rd = 5; id_rs = 5;
      #1;
      checks++;
      if ({pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush} !== 7'b0011101) begin
         $display("FAIL lu_rs got %b exp 0011101",
                  {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush});
         errors++;
      end
      tick();
      checks++;
      if (flush_cnt !== 32'd1) begin
         $display("FAIL lu_flush_cnt got %0d exp 1", flush_cnt);
         errors++;
      end
      ex_rd = 0; id_rs = 0;
      #1;
      checks++;
      if ({pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush} !== 7'b1111100) begin
         $display("FAIL lu_r0 got %b exp 1111100",
                  {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush});
         errors++;
      end
      tick();
      ex_rd = 7; id_rs = 3; id_rt = 7; id_uses_rt = 0;
      #1;
      checks++;
      if ({pc_en, ifid_en, idex_flush} !== 3'b110) begin
         $display("FAIL lu_rt_unused got %b exp 110", {pc_en, ifid_en, idex_flush});
         errors++;
      end
      tick();
      id_uses_rt = 1;
      #1;
      checks++;
      if ({pc_en, ifid_en, idex_flush} !== 3'b001) begin
         $display("FAIL lu_rt_used got %b exp 001", {pc_en, ifid_en, idex_flush});
         errors++;
      end
      tick();
      checks++;
      if ({flush_cnt, stall_cnt} !== {32'd2, 32'd0}) begin
         $display("FAIL lu_counts got flush=%0d stall=%0d exp 2 0", flush_cnt, stall_cnt);
         errors++;
      end
      clear_inputs();
   endtask

   task automatic test_dmem_wait();
      mem_req = 1; dhit = 1; ihit = 0;
      #1;
      checks++;
      if ({dmem_gate, pc_en, memwb_en} !== 3'b100) begin
         $display("FAIL dmem_req got %b exp 100", {dmem_gate, pc_en, memwb_en});
         errors++;
      end
      tick();
      dhit = 0;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if ({dmem_gate, pc_en, ifid_en, idex_en, exmem_en, memwb_en} !== 6'b000000) begin
            $display("FAIL ddone_hold%0d got %b exp 000000", c,
                     {dmem_gate, pc_en, ifid_en, idex_en, exmem_en, memwb_en});
            errors++;
         end
         tick();
      end
      ihit = 1;
      #1;
      checks++;
      if ({dmem_gate, pc_en, ifid_en, idex_en, exmem_en, memwb_en} !== 6'b011111) begin
         $display("FAIL ddone_release got %b exp 011111",
                  {dmem_gate, pc_en, ifid_en, idex_en, exmem_en, memwb_en});
         errors++;
      end
      tick();
      mem_req = 0;
      #1;
      checks++;
      if ({dmem_gate, stall_cnt} !== {1'b1, 32'd3}) begin
         $display("FAIL ddone_exit got gate=%b stall=%0d exp 1 3", dmem_gate, stall_cnt);
         errors++;
      end
      clear_inputs();
   endtask

   task automatic test_branch();
      ihit = 1; ex_branch_taken = 1; ex_memread = 1; ex_rd = 5; id_rs = 5; id_jump = 1;
      #1;
      checks++;
      if ({pc_sel, pc_en, ifid_en, ifid_flush, idex_flush} !== 6'b011111) begin
         $display("FAIL branch_prio got %b exp 011111",
                  {pc_sel, pc_en, ifid_en, ifid_flush, idex_flush});
         errors++;
      end
      tick();
      checks++;
      if (flush_cnt !== 32'd3) begin
         $display("FAIL branch_flush_cnt got %0d exp 3", flush_cnt);
         errors++;
      end
      clear_inputs();
      ihit = 1; id_jump = 1;
      #1;
      checks++;
      if ({pc_sel, pc_en, ifid_flush, idex_flush} !== 5'b10110) begin
         $display("FAIL jump got %b exp 10110", {pc_sel, pc_en, ifid_flush, idex_flush});
         errors++;
      end
      tick();
      ihit = 0; id_jump = 0; ex_branch_taken = 1;
      #1;
      checks++;
      if ({pc_sel, pc_en, ifid_flush, idex_flush} !== 5'b00000) begin
         $display("FAIL branch_noadv got %b exp 00000", {pc_sel, pc_en, ifid_flush, idex_flush});
         errors++;
      end
      tick();
      checks++;
      if ({flush_cnt, stall_cnt} !== {32'd4, 32'd4}) begin
         $display("FAIL branch_counts got flush=%0d stall=%0d exp 4 4", flush_cnt, stall_cnt);
         errors++;
      end
      clear_inputs();
   endtask

   task automatic test_stall_wrap();
      #1 nRST = 1'b0;
      #1 nRST = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (pc_en !== 1'b0) begin
            $display("FAIL stall_pc_en%0d got %b exp 0", c, pc_en);
            errors++;
         end
         tick();
         if (c == 2) begin
            checks++;
            if (s_stall_cnt !== 2'd3) begin
               $display("FAIL wrap_preload got %0d exp 3", s_stall_cnt);
               errors++;
            end
         end
      end
      checks++;
      if ({stall_cnt, s_stall_cnt} !== {32'd4, 2'd0}) begin
         $display("FAIL stall_wrap got stall=%0d small=%0d exp 4 0", stall_cnt, s_stall_cnt);
         errors++;
      end
   endtask

   task automatic test_halt();
      ihit = 1; mem_halt = 1;
      #1;
      checks++;
      if ({pc_en, halted} !== 2'b10) begin
         $display("FAIL halt_enter got %b exp 10", {pc_en, halted});
         errors++;
      end
      tick();
      mem_halt = 0;
      for (int c = 0; c < 3; c++) begin
         ihit = (c != 1); ex_branch_taken = 1; id_jump = 1;
         #1;
         checks++;
         if ({halted, dmem_gate, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}
             !== 9'b100000000) begin
            $display("FAIL halt_hold%0d got %b exp 100000000", c,
                     {halted, dmem_gate, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush});
            errors++;
         end
         tick();
      end
      checks++;
      if ({stall_cnt, flush_cnt} !== {32'd4, 32'd0}) begin
         $display("FAIL halt_counts got stall=%0d flush=%0d exp 4 0", stall_cnt, flush_cnt);
         errors++;
      end
      #1 nRST = 1'b0;
      #1;
      checks++;
      if ({halted, dmem_gate, stall_cnt} !== {1'b0, 1'b1, 32'd0}) begin
         $display("FAIL halt_reset got halted=%b gate=%b stall=%0d exp 0 1 0",
                  halted, dmem_gate, stall_cnt);
         errors++;
      end
      clear_inputs();
      nRST = 1'b1;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_dmem_wait();
      test_branch();
      test_stall_wrap();
      test_halt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
